// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: MEM-stage load/store responder; each 32-bit word goes out as two 16-bit SRAM phases.
// Optional macro SRAM_RANGE_CHECK_EN answers out-of-range requests at once with addr_err instead of an SRAM cycle.
module sram_mem_ctrl #(
  parameter int          SRAM_ADDR_W = 18,
  parameter int          WAIT_CYCLES = 5,
  parameter logic [31:0] MEM_BASE    = 32'd1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  input  logic [31:0]            ALU_result,
  input  logic [31:0]            Val_Rm,
  output logic                   ready,
  output logic [31:0]            read_data,
  output logic                   addr_err,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [15:0]            SRAM_DQ,
  output logic                   SRAM_WE_N
);
  localparam int            CW   = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          counter_q, counter_d;
  logic [SRAM_ADDR_W-2:0] wa_q, wa_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   write_q, write_d;
  logic [31:0]            read_data_q, read_data_d;

  logic [31:0] wa_full;
  logic        req;
  logic        phase_end;
  logic        range_err;
  logic        dq_oe;
  logic [15:0] dq_out;

  assign req       = MEM_R_EN | MEM_W_EN;
  assign wa_full   = (ALU_result - MEM_BASE) >> 2;
  assign phase_end = (counter_q == LAST);

`ifdef SRAM_RANGE_CHECK_EN
  logic addr_err_q, addr_err_d;

  assign range_err  = (ALU_result < MEM_BASE) || (wa_full[31:SRAM_ADDR_W-1] != '0);
  assign addr_err_d = (state_q == IDLE) && req && range_err;
  assign addr_err   = addr_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) addr_err_q <= 1'b0;
    else      addr_err_q <= addr_err_d;
  end
`else
  // Without the check, high word-address bits are simply dropped.
  logic wa_hi_unused;
  assign wa_hi_unused = ^wa_full[31:SRAM_ADDR_W-1];
  assign range_err    = 1'b0;
  assign addr_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      wa_q        <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      wa_q        <= wa_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      read_data_q <= read_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    wa_d        = wa_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    read_data_d = read_data_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          wa_d      = wa_full[SRAM_ADDR_W-2:0];
          wdata_d   = Val_Rm;
          write_d   = MEM_W_EN;
          counter_d = '0;
          if (range_err) begin
            state_d = DONE;
            if (!MEM_W_EN) read_data_d = '0;
          end else begin
            state_d = LOW;
          end
        end
      end
      LOW: begin
        if (phase_end) begin
          counter_d = '0;
          state_d   = HIGH;
          if (!write_q) read_data_d[15:0] = SRAM_DQ;
        end else begin
          counter_d = counter_q + CW'(1);
        end
      end
      HIGH: begin
        if (phase_end) begin
          counter_d = '0;
          state_d   = DONE;
          if (!write_q) read_data_d[31:16] = SRAM_DQ;
        end else begin
          counter_d = counter_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Last cycle of each write phase keeps data on the bus with WE_N high as a hold cycle.
  always_comb begin
    ready     = ((state_q == IDLE) && !req) || (state_q == DONE);
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = wdata_q[15:0];
    if ((state_q == LOW) || (state_q == HIGH)) begin
      SRAM_ADDR = {wa_q, state_q == HIGH};
      if (write_q) begin
        dq_oe     = 1'b1;
        SRAM_WE_N = phase_end;
        dq_out    = (state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
      end
    end
  end

  assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
  assign read_data = read_data_q;

endmodule
